lock_key_loader: RTL and testbench
==================================

Name: lock_key_loader

Overview:
- Sequences key delivery into the 64-key-input logic-locked netlist.
- Fetches the key byte-wise from an external NVM port over a req/ack handshake, CRC-8 checks it, then drives a stable 64-bit key bus.
- Until a checked key is present, the key bus is all-zero and key_valid is low; the locked netlist's outputs are treated as untrusted.

Parameters:
- KEY_W, 64, key bus width; must be a multiple of WORD_W.
- WORD_W, 8, NVM data width per transfer.
- NUM_WORDS, KEY_W/WORD_W (8), key bytes fetched; derived, not overridable.
- TIMEOUT, 255, max cycles waiting for nvm_ack per transfer; 8-bit counter.
- MAX_RETRY, 2, reload attempts after CRC failure (used only with the optional feature).

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; begin load; ignored unless IDLE, DONE or ERROR
- zeroize  in  1  level; clears key and aborts any load
- nvm_req  out  1  read request; held until ack
- nvm_addr  out  4  byte address: 0..NUM_WORDS-1 = key bytes, NUM_WORDS = CRC byte
- nvm_ack  in  1  1-cycle; nvm_data valid in this cycle
- nvm_data  in  WORD_W  read data
- key_out  out  KEY_W  to keyIn_0_0..keyIn_0_63; bit i = keyIn_0_i
- key_valid  out  1  key_out holds a CRC-checked key
- busy  out  1  load in progress
- err  out  1  sticky error; cleared by start or zeroize
- err_code  out  2  00 none, 01 CRC mismatch, 10 NVM timeout

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; shadow register, CRC and counters cleared.
- FSM states: IDLE, REQ, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start: go to REQ.
  - addr = 0; crc = 0x00; err = 0; busy = 1.
  - key_valid drops to 0 and key_out goes to 0 on the same edge.
- REQ: nvm_req = 1 and nvm_addr stable until nvm_ack.
  - On ack with addr < NUM_WORDS: shadow[addr*8 +: 8] <= nvm_data; crc <= crc8(crc, nvm_data); addr++; stay in REQ.
  - Between transfers nvm_req deasserts for exactly 1 cycle.
- REQ, ack with addr == NUM_WORDS: capture the check byte and go to CHECK.
- CHECK (1 cycle):
  - Match: key_out <= shadow; key_valid <= 1; go to DONE.
  - Mismatch: err = 1, err_code = 01; go to ERROR.
- CRC-8: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR. Byte 0 is processed first.
- Timeout: wait counter resets on each new request. When it reaches TIMEOUT without ack: err_code = 10, go to ERROR, nvm_req drops.
- Latency: start to key_valid = 9 transfers + 8 idle gaps + 2 cycles (start edge and CHECK), given 0-wait ack.
- key_out changes only on the CHECK->DONE edge. It never shows partial keys (shadow-register isolation).
- zeroize: highest priority. Next edge: key_out = 0, shadow = 0, key_valid = 0, busy = 0, err = 0, nvm_req = 0, state IDLE. start is ignored while zeroize is high.
- nvm_ack outside REQ is ignored. start during REQ/CHECK is ignored.
- Reset mid-load: the async clear behaves exactly as at power-up. No partial key survives.

Optional Feature:
- Macro: LOCK_KEY_LOADER_RETRY_EN.
- Defined:
  - A CRC mismatch restarts the load from addr 0 without asserting err, up to MAX_RETRY times. The retry counter is 2 bits.
  - err/err_code 01 is raised only after MAX_RETRY+1 total failures.
  - Timeout never retries.
  - Retry counter is cleared on start and zeroize.
- Undefined: the first mismatch goes to ERROR. No retry counter logic is present.

Decomposition:
- Package lock_key_pkg:
  - FSM state enum.
  - err_code enum constants.
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00.
  - Function crc8_byte(crc, data).
- One sub-module: lock_key_crc8. A combinational byte-wise CRC step, instantiated once, so the bench can reuse it as a golden model.

Test Plan:
- Zero-wait load of key 0x0000_0000_0000_0000 with CRC byte 0x00 -> nvm_addr sequence 0..8; key_valid=1 with key_out=0 on the cycle after CHECK; err=0.
- Load key 0x0123_4567_89AB_CDEF (byte0 = 0xEF) with model CRC and random 0-20-cycle ack delays -> key_out = 0x0123456789ABCDEF; key_out stays 0 throughout the load.
- Same key with CRC byte = model^0x01, macro undefined -> err=1, err_code=01, key_valid=0, key_out=0.
  - Macro defined: 3 full address sweeps occur before err.
- nvm_ack withheld at addr 3 -> after 255 wait cycles err_code=10, nvm_req=0, busy=0.
  - A subsequent start with a good key -> key_valid=1 and err cleared.
- After a valid key loads, assert zeroize for 1 cycle mid-way through a second load -> next edge key_out=0, key_valid=0, state IDLE; later acks are ignored.
- Drop rst_n asynchronously at addr 5 -> all outputs 0 immediately, before the next clock edge.
  - After release, start plus a good key -> correct key_valid; no stale bytes from the aborted load.

Source files
------------

// File: rtl/lock_key_pkg.sv
// Shared constants and the CRC-8 byte step for the lock key loader.
package lock_key_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StCheck = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StError = 3'd4;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrCrc     = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // MSB-first, non-reflected CRC-8 over one byte.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/lock_key_crc8.sv
// Combinational byte-wise CRC-8 step.
module lock_key_crc8
  import lock_key_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  assign crc_out = crc8_byte(crc_in, data);

endmodule

// File: rtl/lock_key_loader.sv
// Fetches the lock key from NVM, CRC-8 checks it and drives a stable key bus.
// Optional CRC-failure retry is enabled by defining LOCK_KEY_LOADER_RETRY_EN.
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int unsigned KEY_W     = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              zeroize,
  output logic              nvm_req,
  output logic [3:0]        nvm_addr,
  input  logic              nvm_ack,
  input  logic [WORD_W-1:0] nvm_data,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned NUM_WORDS = KEY_W / WORD_W;

  logic [2:0]        state_q, state_d;
  logic [3:0]        addr_q, addr_d;
  logic [7:0]        crc_q, crc_d, crc_next;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        wait_q, wait_d;
  logic [KEY_W-1:0]  shadow_q, shadow_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
`ifdef LOCK_KEY_LOADER_RETRY_EN
  logic [1:0]        retry_q, retry_d;
`endif

  lock_key_crc8 u_crc (
    .crc_in  (crc_q),
    .data    (nvm_data),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    crc_d    = crc_q;
    chk_d    = chk_q;
    wait_d   = wait_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    req_d    = req_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    err_d    = err_q;
    code_d   = code_q;
`ifdef LOCK_KEY_LOADER_RETRY_EN
    retry_d  = retry_q;
`endif
    if (zeroize) begin
      state_d  = StIdle;
      addr_d   = '0;
      crc_d    = CRC8_INIT;
      chk_d    = '0;
      wait_d   = '0;
      shadow_d = '0;
      key_d    = '0;
      req_d    = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      err_d    = 1'b0;
      code_d   = ErrNone;
`ifdef LOCK_KEY_LOADER_RETRY_EN
      retry_d  = '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_d  = StReq;
            addr_d   = '0;
            crc_d    = CRC8_INIT;
            wait_d   = '0;
            shadow_d = '0;
            key_d    = '0;
            req_d    = 1'b1;
            valid_d  = 1'b0;
            busy_d   = 1'b1;
            err_d    = 1'b0;
            code_d   = ErrNone;
`ifdef LOCK_KEY_LOADER_RETRY_EN
            retry_d  = '0;
`endif
          end
        end
        StReq: begin
          if (!req_q) begin
            // One-cycle gap after each transfer; the wait budget restarts here.
            req_d  = 1'b1;
            wait_d = '0;
          end else if (nvm_ack) begin
            req_d  = 1'b0;
            wait_d = '0;
            if (addr_q == 4'(NUM_WORDS)) begin
              chk_d   = nvm_data;
              state_d = StCheck;
            end else begin
              for (int i = 0; i < NUM_WORDS; i++) begin
                if (addr_q == 4'(i)) shadow_d[i*WORD_W +: WORD_W] = nvm_data;
              end
              crc_d  = crc_next;
              addr_d = addr_q + 4'd1;
            end
          end else if (wait_q == 8'(TIMEOUT - 1)) begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            code_d  = ErrTimeout;
            state_d = StError;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        StCheck: begin
          if (chk_q == crc_q) begin
            key_d   = shadow_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
`ifdef LOCK_KEY_LOADER_RETRY_EN
          end else if (retry_q < 2'(MAX_RETRY)) begin
            retry_d = retry_q + 2'd1;
            addr_d  = '0;
            crc_d   = CRC8_INIT;
            wait_d  = '0;
            req_d   = 1'b1;
            state_d = StReq;
`endif
          end else begin
            busy_d  = 1'b0;
            err_d   = 1'b1;
            code_d  = ErrCrc;
            state_d = StError;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      crc_q    <= CRC8_INIT;
      chk_q    <= '0;
      wait_q   <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ErrNone;
`ifdef LOCK_KEY_LOADER_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      crc_q    <= crc_d;
      chk_q    <= chk_d;
      wait_q   <= wait_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      code_q   <= code_d;
`ifdef LOCK_KEY_LOADER_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign nvm_req   = req_q;
  assign nvm_addr  = addr_q;
  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader with a behavioural NVM responder.
module tb_lock_key_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        zeroize = 1'b0;
  logic        nvm_req;
  logic [3:0]  nvm_addr;
  logic        nvm_ack = 1'b0;
  logic [7:0]  nvm_data = 8'h00;
  logic [63:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  int total = 0;
  int bad = 0;

  lock_key_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .zeroize   (zeroize),
    .nvm_req   (nvm_req),
    .nvm_addr  (nvm_addr),
    .nvm_ack   (nvm_ack),
    .nvm_data  (nvm_data),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // NVM responder state
  logic [7:0] mem [0:8];
  logic [3:0] addr_log [$];
  int  delay = 0;
  int  wcnt = 0;
  int  sweeps = 0;
  int  hold_cycles = 0;
  bit  rnd_mode = 0;
  bit  hold_en = 0;
  bit  force_ack = 0;
  bit  partial_seen = 0;

  always @(negedge clk) begin
    if (force_ack) begin
      nvm_ack  = 1'b1;
      nvm_data = 8'hA5;
    end else if (nvm_req) begin
      if (hold_en && nvm_addr == 4'd3) begin
        nvm_ack = 1'b0;
        hold_cycles++;
      end else if (wcnt >= delay) begin
        nvm_ack  = 1'b1;
        nvm_data = mem[nvm_addr];
        addr_log.push_back(nvm_addr);
        if (nvm_addr == 4'd0) sweeps++;
        wcnt  = 0;
        delay = rnd_mode ? int'($urandom_range(0, 20)) : 0;
      end else begin
        nvm_ack = 1'b0;
        wcnt++;
      end
    end else begin
      nvm_ack = 1'b0;
    end
  end

  always @(negedge clk) if (!key_valid && key_out != 64'h0) partial_seen = 1;

  // Bit-serial reference CRC-8 (poly 0x07, init 0), byte 0 first.
  function automatic logic [7:0] crc_model(input logic [63:0] k);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ k[i*8+b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input logic [63:0] k, input logic [7:0] crc_xor);
    for (int i = 0; i < 8; i++) mem[i] = k[i*8 +: 8];
    mem[8] = crc_model(k) ^ crc_xor;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr_log.delete();
    sweeps = 0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  localparam logic [63:0] KeyA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] KeyB = 64'hFEDC_BA98_7654_3210;

  initial begin
    int n;
    logic [63:0] all_out;

    // Reset state
    #1;
    all_out = {49'h0, nvm_req, nvm_addr, key_valid, busy, err, err_code, 5'h0} | key_out;
    check("reset_outputs", all_out, 64'h0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Zero key, zero-wait acks, CRC 0x00
    set_key(64'h0, 8'h00);
    check("zero_crc_byte", 64'(mem[8]), 64'h00);
    pulse_start();
    check("zero_req_first", {63'h0, nvm_req}, 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    n = 0;
    while (!key_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    // The start edge is the first of 9 + 8 + 2 cycles; we began counting after it.
    check("zero_latency", 64'(n), 64'(9 + 8 + 2 - 1));
    check("zero_key", key_out, 64'h0);
    check("zero_err", 64'(err), 64'd0);
    check("zero_nacks", 64'(addr_log.size()), 64'd9);
    for (int i = 0; i < addr_log.size(); i++) check("zero_addr_seq", 64'(addr_log[i]), 64'(i));

    // KeyA with random ack delays
    set_key(KeyA, 8'h00);
    rnd_mode = 1;
    partial_seen = 0;
    pulse_start();
    check("a_valid_dropped", 64'(key_valid), 64'd0);
    wait_idle("a_done", 800);
    rnd_mode = 0;
    delay = 0;
    check("a_valid", 64'(key_valid), 64'd1);
    check("a_key", key_out, KeyA);
    check("a_no_partial", 64'(partial_seen), 64'd0);
    check("a_err", 64'(err), 64'd0);

    // Corrupted CRC byte
    set_key(KeyA, 8'h01);
    pulse_start();
    wait_idle("crc_done", 300);
    check("crc_err", 64'(err), 64'd1);
    check("crc_code", 64'(err_code), 64'd1);
    check("crc_valid", 64'(key_valid), 64'd0);
    check("crc_key", key_out, 64'h0);
`ifdef LOCK_KEY_LOADER_RETRY_EN
    check("crc_sweeps", 64'(sweeps), 64'd3);
`else
    check("crc_sweeps", 64'(sweeps), 64'd1);
`endif

    // Ack withheld at address 3 -> timeout
    set_key(KeyA, 8'h00);
    hold_en = 1;
    hold_cycles = 0;
    pulse_start();
    wait_idle("to_done", 400);
    hold_en = 0;
    check("to_err", 64'(err), 64'd1);
    check("to_code", 64'(err_code), 64'd2);
    check("to_req", 64'(nvm_req), 64'd0);
    check("to_wait_cycles", 64'(hold_cycles), 64'd255);
    pulse_start();
    check("to_err_cleared", 64'(err), 64'd0);
    wait_idle("reload_done", 100);
    check("reload_valid", 64'(key_valid), 64'd1);
    check("reload_code", 64'(err_code), 64'd0);
    check("reload_key", key_out, KeyA);

    // Zeroize with a valid key present
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    check("zdone_key", key_out, 64'h0);
    check("zdone_valid", 64'(key_valid), 64'd0);

    // Zeroize mid-load, start held alongside it, then stray acks
    set_key(KeyB, 8'h00);
    pulse_start();
    n = 0;
    while (addr_log.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("zmid_progress", 64'(addr_log.size() >= 4), 64'd1);
    zeroize = 1'b1;
    start = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    start = 1'b0;
    check("zmid_busy", 64'(busy), 64'd0);
    check("zmid_req", 64'(nvm_req), 64'd0);
    check("zmid_key", key_out, 64'h0);
    force_ack = 1;
    repeat (3) @(negedge clk);
    force_ack = 0;
    @(negedge clk);
    check("stray_ack_idle", {61'h0, busy, nvm_req, key_valid}, 64'd0);
    check("stray_ack_addr", 64'(nvm_addr), 64'd0);

    // Async reset mid-load at address 5
    pulse_start();
    n = 0;
    while (!(nvm_req && nvm_addr == 4'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_addr5", 64'(nvm_addr), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    all_out = {49'h0, nvm_req, nvm_addr, key_valid, busy, err, err_code, 5'h0} | key_out;
    check("rst_async_clear", all_out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_key(KeyA, 8'h00);
    pulse_start();
    wait_idle("post_rst_done", 100);
    check("post_rst_valid", 64'(key_valid), 64'd1);
    check("post_rst_key", key_out, KeyA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
